// File: rtl/inc_cnt.sv
// Bounded up/down counter with saturate or wrap at the bounds, synchronous clear,
// clamped parallel load, a combinational cascade carry and a sticky saturation flag.
module inc_cnt #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 9,
  parameter int WRAP    = 0
) (
  input  logic             CLK,
  input  logic             R_N,
  input  logic             CE,
  input  logic             DIR,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             WRAP_P,
  output logic             SAT
);

  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= (2 ** WIDTH) - 1)) begin : g_bad_bounds
    $error("inc_cnt: bounds must satisfy 0 <= MIN_VAL < MAX_VAL <= 2^WIDTH-1");
  end

  // One extra bit keeps +1 at MAX_VAL = 2^WIDTH-1 from silently wrapping.
  localparam logic [WIDTH:0] MIN_E = (WIDTH + 1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_E = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE_E = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic [WIDTH:0]   q_ext_s, d_ext_s, nxt_s;
  logic             at_bound_s;

  assign q_ext_s    = {1'b0, q_q};
  assign d_ext_s    = {1'b0, D};
  assign at_bound_s = DIR ? (q_ext_s == MIN_E) : (q_ext_s == MAX_E);

  // CO is gated by R_N so a held reset never looks like a bound hit downstream.
  assign CO = R_N & CE & ~CLR & ~LD & at_bound_s;

  // Next-state selection: clear beats load beats count.
  always_comb begin
    nxt_s  = q_ext_s;
    sat_d  = sat_q;
    wrap_d = 1'b0;
    if (CLR) begin
      nxt_s = MIN_E;
      sat_d = 1'b0;
    end else if (LD) begin
      if (d_ext_s > MAX_E) begin
        nxt_s = MAX_E;
      end else if (d_ext_s < MIN_E) begin
        nxt_s = MIN_E;
      end else begin
        nxt_s = d_ext_s;
      end
    end else if (CE) begin
      if (!at_bound_s) begin
        nxt_s = DIR ? (q_ext_s - ONE_E) : (q_ext_s + ONE_E);
      end else if (WRAP != 0) begin
        nxt_s  = DIR ? MAX_E : MIN_E;
        wrap_d = 1'b1;
      end else begin
        sat_d = 1'b1;
      end
    end else begin
      nxt_s = q_ext_s;
    end
    q_d = WIDTH'(nxt_s);
  end

  // State registers with asynchronous reset to the lower bound.
  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      q_q    <= WIDTH'(MIN_VAL);
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign Q      = q_q;
  assign WRAP_P = wrap_q;
  assign SAT    = sat_q;

endmodule

// File: tb/tb_inc_cnt.sv
// Self-checking bench: several inc_cnt configurations share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_inc_cnt;
  localparam int N = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ce_s = 1'b0, dir_s = 1'b0, clr_s = 1'b0, ld_s = 1'b0;
  logic [3:0] d_s = 4'd0;
  logic [3:0] q   [N];
  logic       co  [N];
  logic       wp  [N];
  logic       sat [N];

  // Instance configs: 0 sat 0..9, 1/2 wrap 0..9 cascaded, 3 sat 3..9,
  // 4 sat 0..15, 5 wrap 0..15, 6 wrap 8..9.
  int pmin  [N] = '{0, 0, 0, 3, 0, 0, 8};
  int pmax  [N] = '{9, 9, 9, 9, 15, 15, 9};
  int pwrap [N] = '{0, 1, 1, 0, 0, 1, 1};

  int mq   [N];
  bit msat [N];
  bit mwp  [N];
  bit co_seen [N];
  bit co_exp  [N];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inc_cnt #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .WRAP(0)) u0 (.CLK(clk), .R_N(rst_n), .CE(ce_s), .DIR(dir_s),
    .CLR(clr_s), .LD(ld_s), .D(d_s), .Q(q[0]), .CO(co[0]), .WRAP_P(wp[0]), .SAT(sat[0]));
  inc_cnt #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .WRAP(1)) u1 (.CLK(clk), .R_N(rst_n), .CE(ce_s), .DIR(dir_s),
    .CLR(clr_s), .LD(ld_s), .D(d_s), .Q(q[1]), .CO(co[1]), .WRAP_P(wp[1]), .SAT(sat[1]));
  inc_cnt #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(9), .WRAP(1)) u2 (.CLK(clk), .R_N(rst_n), .CE(co[1]), .DIR(dir_s),
    .CLR(clr_s), .LD(1'b0), .D(d_s), .Q(q[2]), .CO(co[2]), .WRAP_P(wp[2]), .SAT(sat[2]));
  inc_cnt #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(9), .WRAP(0)) u3 (.CLK(clk), .R_N(rst_n), .CE(ce_s), .DIR(dir_s),
    .CLR(clr_s), .LD(ld_s), .D(d_s), .Q(q[3]), .CO(co[3]), .WRAP_P(wp[3]), .SAT(sat[3]));
  inc_cnt #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .WRAP(0)) u4 (.CLK(clk), .R_N(rst_n), .CE(ce_s), .DIR(dir_s),
    .CLR(clr_s), .LD(ld_s), .D(d_s), .Q(q[4]), .CO(co[4]), .WRAP_P(wp[4]), .SAT(sat[4]));
  inc_cnt #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .WRAP(1)) u5 (.CLK(clk), .R_N(rst_n), .CE(ce_s), .DIR(dir_s),
    .CLR(clr_s), .LD(ld_s), .D(d_s), .Q(q[5]), .CO(co[5]), .WRAP_P(wp[5]), .SAT(sat[5]));
  inc_cnt #(.WIDTH(4), .MIN_VAL(8), .MAX_VAL(9), .WRAP(1)) u6 (.CLK(clk), .R_N(rst_n), .CE(ce_s), .DIR(dir_s),
    .CLR(clr_s), .LD(ld_s), .D(d_s), .Q(q[6]), .CO(co[6]), .WRAP_P(wp[6]), .SAT(sat[6]));

  function automatic bit at_bound(int i);
    return dir_s ? (mq[i] == pmin[i]) : (mq[i] == pmax[i]);
  endfunction

  function automatic bit ce_of(int i);
    if (i == 2) return rst_n && ce_s && !clr_s && !ld_s && at_bound(1);
    return ce_s;
  endfunction

  function automatic bit ld_of(int i);
    return (i == 2) ? 1'b0 : ld_s;
  endfunction

  function automatic bit model_co(int i);
    return rst_n && ce_of(i) && !clr_s && !ld_of(i) && at_bound(i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i] = pmin[i]; msat[i] = 1'b0; mwp[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    bit ce_v [N];
    bit ld_v [N];
    int dv;
    dv = int'(d_s);
    for (int i = 0; i < N; i++) begin
      ce_v[i] = ce_of(i); ld_v[i] = ld_of(i);
    end
    for (int i = 0; i < N; i++) begin
      mwp[i] = 1'b0;
      if (clr_s) begin
        mq[i] = pmin[i]; msat[i] = 1'b0;
      end else if (ld_v[i]) begin
        mq[i] = (dv > pmax[i]) ? pmax[i] : ((dv < pmin[i]) ? pmin[i] : dv);
      end else if (ce_v[i]) begin
        if (!dir_s && mq[i] < pmax[i]) mq[i] = mq[i] + 1;
        else if (dir_s && mq[i] > pmin[i]) mq[i] = mq[i] - 1;
        else if (pwrap[i] != 0) begin
          mq[i] = dir_s ? pmax[i] : pmin[i]; mwp[i] = 1'b1;
        end else msat[i] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of stimulus, capture CO before the edge, advance the model.
  task automatic cycle(input bit ce, input bit dir, input bit clr, input bit ld, input logic [3:0] d);
    ce_s = ce; dir_s = dir; clr_s = clr; ld_s = ld; d_s = d;
    #2;
    for (int i = 0; i < N; i++) begin
      co_seen[i] = co[i]; co_exp[i] = model_co(i);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    ce_s = 1'b1; dir_s = 1'b1; clr_s = 1'b0; ld_s = 1'b0; d_s = 4'd0;
    model_reset();
    #2;
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({q[i], wp[i], sat[i], co[i]} !== {4'(pmin[i]), 3'b000})
        begin errors++; $display("FAIL reset[%0d] q=%0d wp=%b sat=%b co=%b want q=%0d 0 0 0", i, q[i], wp[i], sat[i], co[i], pmin[i]); end
    end
    @(posedge clk); #1;
    checks++;
    if ({q[0], co[0]} !== {4'd0, 1'b0})
      begin errors++; $display("FAIL reset_held q=%0d co=%b want 0 0", q[0], co[0]); end
    rst_n = 1'b1; ce_s = 1'b0;
  endtask

  task automatic test_count_up();
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++;
      if ({q[0], sat[0], co_seen[0]} !== {4'((k <= 9) ? k : 9), (k >= 10), (k >= 10)})
        begin errors++; $display("FAIL count_up k=%0d q=%0d sat=%b co=%b", k, q[0], sat[0], co_seen[0]); end
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({q[i], wp[i], sat[i], co_seen[i]} !== {4'(mq[i]), mwp[i], msat[i], co_exp[i]})
          begin errors++; $display("FAIL count_model[%0d] got %0d/%b/%b/%b want %0d/%b/%b/%b", i, q[i], wp[i], sat[i], co_seen[i], mq[i], mwp[i], msat[i], co_exp[i]); end
      end
    end
  endtask

  task automatic test_priority();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    checks++;
    if ({q[0], sat[0], q[6]} !== {4'd5, 1'b1, 4'd8})
      begin errors++; $display("FAIL load5 q0=%0d sat0=%b q6=%0d want 5 1 8", q[0], sat[0], q[6]); end
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd5);
    checks++;
    if ({q[0], sat[0]} !== {4'd0, 1'b0})
      begin errors++; $display("FAIL clr_prio q0=%0d sat0=%b want 0 0", q[0], sat[0]); end
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'hE);
    checks++;
    if ({q[0], q[4], wp[5]} !== {4'd9, 4'd14, 1'b0})
      begin errors++; $display("FAIL load_hi q0=%0d q4=%0d wp5=%b want 9 14 0", q[0], q[4], wp[5]); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    checks++;
    if ({q[3], q[0]} !== {4'd3, 4'd1})
      begin errors++; $display("FAIL load_lo q3=%0d q0=%0d want 3 1", q[3], q[0]); end
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({q[i], wp[i], sat[i]} !== {4'(mq[i]), mwp[i], msat[i]})
        begin errors++; $display("FAIL prio_model[%0d] got %0d/%b/%b want %0d/%b/%b", i, q[i], wp[i], sat[i], mq[i], mwp[i], msat[i]); end
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++;
      if ({q[1], wp[1], sat[1]} !== {4'(k % 10), (k == 10), 1'b0})
        begin errors++; $display("FAIL wrap_up k=%0d q=%0d wp=%b sat=%b", k, q[1], wp[1], sat[1]); end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({q[1], wp[1]} !== {4'd0, 1'b0})
      begin errors++; $display("FAIL wrap_pulse_end q=%0d wp=%b want 0 0", q[1], wp[1]); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({q[1], wp[1], q[6], wp[6]} !== {4'd9, 1'b1, 4'd9, 1'b1})
      begin errors++; $display("FAIL wrap_down q1=%0d wp1=%b q6=%0d wp6=%b want 9 1 9 1", q[1], wp[1], q[6], wp[6]); end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({q[6], wp[6]} !== {4'd8, 1'b1})
      begin errors++; $display("FAIL wrap_b2b q6=%0d wp6=%b want 8 1", q[6], wp[6]); end
  endtask

  task automatic test_cascade();
    int pulses;
    pulses = 0;
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 100; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      if (co_seen[1]) pulses++;
      if (k == 99) begin
        checks++;
        if (q[2] !== 4'd9) begin errors++; $display("FAIL cascade_99 q2=%0d want 9", q[2]); end
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({q[i], wp[i], sat[i], co_seen[i]} !== {4'(mq[i]), mwp[i], msat[i], co_exp[i]})
          begin errors++; $display("FAIL cascade_model[%0d] k=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", i, k, q[i], wp[i], sat[i], co_seen[i], mq[i], mwp[i], msat[i], co_exp[i]); end
      end
    end
    checks++;
    if ({q[1], q[2], pulses} !== {4'd0, 4'd0, 32'd10})
      begin errors++; $display("FAIL cascade_end q1=%0d q2=%0d pulses=%0d want 0 0 10", q[1], q[2], pulses); end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
    checks++;
    if ({q[0], sat[0]} !== {4'd7, 1'b1})
      begin errors++; $display("FAIL pre_reset q0=%0d sat0=%b want 7 1", q[0], sat[0]); end
    ce_s = 1'b1; dir_s = 1'b1; ld_s = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({q[0], sat[0], co[0], wp[0]} !== {4'd0, 3'b000})
      begin errors++; $display("FAIL async_reset q0=%0d sat0=%b co0=%b wp0=%b want 0 0 0 0", q[0], sat[0], co[0], wp[0]); end
    #2 rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    checks++;
    if ({q[0], sat[0]} !== {4'd1, 1'b0})
      begin errors++; $display("FAIL resume q0=%0d sat0=%b want 1 0", q[0], sat[0]); end
  endtask

  task automatic test_full_range();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 18; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      checks++;
      if ({q[4], sat[4], q[5], wp[5]} !== {4'((k <= 15) ? k : 15), (k >= 16), 4'(k % 16), (k == 16)})
        begin errors++; $display("FAIL full_range k=%0d q4=%0d sat4=%b q5=%0d wp5=%b", k, q[4], sat[4], q[5], wp[5]); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      for (int i = 0; i < N; i++) begin
        checks++;
        if ({q[i], wp[i], sat[i], co_seen[i]} !== {4'(mq[i]), mwp[i], msat[i], co_exp[i]})
          begin errors++; $display("FAIL random[%0d] k=%0d got %0d/%b/%b/%b want %0d/%b/%b/%b", i, k, q[i], wp[i], sat[i], co_seen[i], mq[i], mwp[i], msat[i], co_exp[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_priority();
    test_wrap();
    test_cascade();
    test_async_reset();
    test_full_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inc_cnt.md
Name: inc_cnt

Overview:
Parametrised bounded up/down counter. Generalises the saturating incrementer used in the UART datapath for bit/sample/baud counting.
Adds programmable width and bounds, selectable saturate or wrap mode, direction control, synchronous clear and parallel load. Adds cascade carry-out, wrap pulse and sticky saturation flag.
Sits beside the UART baud and bit-position logic; carry-out chains instances into multi-digit counters.

Parameters:
WIDTH, 4, counter width in bits.
MIN_VAL, 0, lower bound; value after reset and clear.
MAX_VAL, 9, upper bound; elaboration error unless MIN_VAL < MAX_VAL <= 2^WIDTH-1.
WRAP, 0, 0 = saturate at bound, 1 = wrap to opposite bound.

Ports:
CLK  in  1  clock, rising edge.
R_N  in  1  asynchronous active-low reset.
CE  in  1  count enable; one step per cycle when high.
DIR  in  1  0 = count up, 1 = count down.
CLR  in  1  synchronous clear to MIN_VAL.
LD  in  1  synchronous parallel load from D.
D  in  WIDTH  load value.
Q  out  WIDTH  counter value (registered).
CO  out  1  carry/borrow out (combinational).
WRAP_P  out  1  registered one-cycle wrap pulse.
SAT  out  1  sticky saturation flag (registered).

Behaviour:
- Reset (R_N=0, asynchronous, no clock needed):
  - Q=MIN_VAL, WRAP_P=0, SAT=0.
  - CO=0 for the whole time R_N is low.
- Priority per rising edge: CLR > LD > CE. Lower-priority requests in the same cycle are ignored.
- CLR=1:
  - Q<=MIN_VAL, SAT<=0, WRAP_P<=0.
- LD=1 (CLR=0):
  - Q<=D, clamped: D>MAX_VAL loads MAX_VAL; D<MIN_VAL loads MIN_VAL.
  - SAT unchanged. WRAP_P<=0.
- CE=1 (CLR=0, LD=0):
  - Up, Q<MAX_VAL: Q<=Q+1.
  - Down, Q>MIN_VAL: Q<=Q-1.
  - At bound in the current direction (Q==MAX_VAL up, Q==MIN_VAL down):
    - WRAP=1: Q<=MIN_VAL (up) or MAX_VAL (down); WRAP_P<=1.
    - WRAP=0: Q holds; SAT<=1.
- CE=0 with no CLR/LD: Q and SAT hold.
- WRAP_P:
  - Exactly one cycle high after each wrap edge; 0 otherwise.
  - Back-to-back wraps (e.g. MIN_VAL=MAX_VAL-1 counting continuously) keep WRAP_P high on consecutive cycles.
- CO = CE & ~CLR & ~LD & (at bound in current direction).
  - Asserted in both modes. Intended as CE of the next cascaded stage.
  - Purely combinational from inputs and Q; no extra latency.
- DIR may change on any cycle; it takes effect on the same edge.
- Arithmetic is done in WIDTH+1 bits internally. Q never leaves [MIN_VAL, MAX_VAL], including when MAX_VAL = 2^WIDTH-1.
- Reset asserted mid-count: immediate return to reset values. After R_N deasserts, the first count occurs on the first edge with CE=1.
- Latency: Q and WRAP_P update on the edge where the request is sampled; CO in the same cycle.

Test Plan:
- Reset and count: WIDTH=4, MIN=0, MAX=9, WRAP=0; release R_N, CE=1, DIR=0 for 12 cycles -> Q=1..9 then holds 9; SAT=1 from the 10th edge; CO=1 while Q=9.
- Wrap mode: WRAP=1, up from 0 for 10 edges -> Q returns to 0 on the 10th edge; WRAP_P high one cycle; SAT stays 0. Down from 0 -> Q=9 with WRAP_P pulse.
- Priority and clamp:
  - CLR=LD=CE=1, Q=5 -> Q=0, SAT=0.
  - LD=1, D=4'hE -> Q=9.
  - MIN=3, LD=1, D=1 -> Q=3.
- Cascade: two instances (MAX=9, WRAP=1), stage-1 CE from stage-0 CO, 100 enables -> stage-1 Q=0 after 100, stage-1 Q=9 at enable 99; CO chain pulses once per 10 counts.
- Async reset mid-operation: assert R_N=0 between edges at Q=7, SAT=1 -> Q=0, SAT=0, CO=0 immediately without a clock edge; counting resumes from 0.
- Full-range bound: WIDTH=4, MAX=15, WRAP=0, up past 15 -> Q holds 15, no overflow to 0; with WRAP=1 -> 15 to 0 and WRAP_P=1.
